// File: rtl/banco_pkg.sv
// Shared types and default parameter values for the parameterised register bank.
// The clear FSM state type is used by the top and visible to the read ports.
package banco_pkg;

   typedef enum logic [0:0] {
      IDLE     = 1'b0,
      CLEARING = 1'b1
   } banco_state_e;

   localparam int DEF_DATA_W    = 16;
   localparam int DEF_NUM_REGS  = 8;
   localparam int DEF_N_RD      = 2;
   localparam int DEF_ZERO_REG0 = 0;

endpackage

// File: rtl/banco_read_port.sv
// One read port of the register bank: address mux, same-cycle write bypass with
// byte merge, optional hard-zero register 0, and registered outputs.
module banco_read_port
   import banco_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int NUM_REGS  = DEF_NUM_REGS,
   parameter int ZERO_REG0 = DEF_ZERO_REG0
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 rd_en_i,
   input  logic [$clog2(NUM_REGS)-1:0]          rd_addr_i,
   input  logic [NUM_REGS-1:0][DATA_W-1:0]      regs_i,
   input  logic [NUM_REGS-1:0]                  written_i,
   input  logic                                 wr_accept_i,
   input  logic [$clog2(NUM_REGS)-1:0]          wr_addr_i,
   input  logic [DATA_W-1:0]                    wr_data_i,
   input  logic [DATA_W/8-1:0]                  wr_be_i,
   output logic [DATA_W-1:0]                    rd_data_o,
   output logic                                 rd_vld_o,
   output logic                                 rd_uninit_o
);

   localparam int AW = $clog2(NUM_REGS);
   localparam int NB = DATA_W / 8;

   logic [DATA_W-1:0] rd_data_d;
   logic              rd_uninit_d;
   logic [DATA_W-1:0] rd_data_q;
   logic              rd_vld_q;
   logic              rd_uninit_q;

   // Next read value: stored word, overlaid by any write landing on the same address.
   always_comb begin
      rd_data_d   = regs_i[rd_addr_i];
      rd_uninit_d = ~written_i[rd_addr_i];
      if (wr_accept_i && (wr_addr_i == rd_addr_i)) begin
         for (int b = 0; b < NB; b++) begin
            if (wr_be_i[b]) begin
               rd_data_d[8*b +: 8] = wr_data_i[8*b +: 8];
            end else begin
               rd_data_d[8*b +: 8] = regs_i[rd_addr_i][8*b +: 8];
            end
         end
         rd_uninit_d = 1'b0;
      end else begin
         rd_uninit_d = ~written_i[rd_addr_i];
      end
      if ((ZERO_REG0 != 0) && (rd_addr_i == {AW{1'b0}})) begin
         rd_data_d   = {DATA_W{1'b0}};
         rd_uninit_d = 1'b0;
      end else begin
         rd_uninit_d = rd_uninit_d;
      end
   end

   // Output registers; data and uninit hold their last value between reads.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_data_q   <= {DATA_W{1'b0}};
         rd_vld_q    <= 1'b0;
         rd_uninit_q <= 1'b0;
      end else if (rd_en_i) begin
         rd_data_q   <= rd_data_d;
         rd_vld_q    <= 1'b1;
         rd_uninit_q <= rd_uninit_d;
      end else begin
         rd_vld_q    <= 1'b0;
      end
   end

   assign rd_data_o   = rd_data_q;
   assign rd_vld_o    = rd_vld_q;
   assign rd_uninit_o = rd_uninit_q;

endmodule

// File: rtl/banco_registros_param.sv
// Parameterised register bank with byte-enabled writes, N_RD registered read ports
// and a sequential full-bank clear engine that blocks writes while it runs.
module banco_registros_param
   import banco_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int NUM_REGS  = DEF_NUM_REGS,
   parameter int N_RD      = DEF_N_RD,
   parameter int ZERO_REG0 = DEF_ZERO_REG0
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 wr_valid,
   output logic                                 wr_ready,
   input  logic [$clog2(NUM_REGS)-1:0]          wr_addr,
   input  logic [DATA_W-1:0]                    wr_data,
   input  logic [DATA_W/8-1:0]                  wr_be,
   input  logic [N_RD-1:0]                      rd_en,
   input  logic [N_RD*$clog2(NUM_REGS)-1:0]     rd_addr,
   output logic [N_RD*DATA_W-1:0]               rd_data,
   output logic [N_RD-1:0]                      rd_vld,
   output logic [N_RD-1:0]                      rd_uninit,
   input  logic                                 clr_req,
   output logic                                 clr_busy
);

   localparam int AW = $clog2(NUM_REGS);
   localparam int NB = DATA_W / 8;

   banco_state_e                     state_q;
   logic [AW-1:0]                    clr_idx_q;
   logic [NUM_REGS-1:0][DATA_W-1:0]  regs_q;
   logic [NUM_REGS-1:0]              written_q;
   logic                             wr_accept_s;
   logic                             wr_discard_s;
   logic [DATA_W-1:0]                wr_merged_s;

   // Both handshake outputs decode directly from the state register.
   assign clr_busy     = (state_q == CLEARING);
   assign wr_ready     = ~clr_busy;
   assign wr_accept_s  = wr_valid & wr_ready;
   assign wr_discard_s = (ZERO_REG0 != 0) && (wr_addr == {AW{1'b0}});

   // Byte merge of incoming write data over the currently stored word.
   always_comb begin
      wr_merged_s = regs_q[wr_addr];
      for (int b = 0; b < NB; b++) begin
         if (wr_be[b]) begin
            wr_merged_s[8*b +: 8] = wr_data[8*b +: 8];
         end else begin
            wr_merged_s[8*b +: 8] = regs_q[wr_addr][8*b +: 8];
         end
      end
   end

   // Storage, written flags and the clear FSM.
   always_ff @(posedge clk) begin
      if (reset) begin
         regs_q    <= {(NUM_REGS*DATA_W){1'b0}};
         written_q <= {NUM_REGS{1'b0}};
         state_q   <= IDLE;
         clr_idx_q <= {AW{1'b0}};
      end else begin
         case (state_q)
            IDLE: begin
               if (wr_accept_s && !wr_discard_s) begin
                  regs_q[wr_addr]    <= wr_merged_s;
                  written_q[wr_addr] <= 1'b1;
               end
               if (clr_req) begin
                  state_q   <= CLEARING;
                  clr_idx_q <= {AW{1'b0}};
               end
            end
            CLEARING: begin
               regs_q[clr_idx_q]    <= {DATA_W{1'b0}};
               written_q[clr_idx_q] <= 1'b0;
               clr_idx_q            <= clr_idx_q + AW'(1);
               if (clr_idx_q == AW'(NUM_REGS - 1)) begin
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q   <= IDLE;
               clr_idx_q <= {AW{1'b0}};
            end
         endcase
      end
   end

   for (genvar p = 0; p < N_RD; p++) begin : g_rd
      banco_read_port #(
         .DATA_W    (DATA_W),
         .NUM_REGS  (NUM_REGS),
         .ZERO_REG0 (ZERO_REG0)
      ) u_rd (
         .clk         (clk),
         .reset       (reset),
         .rd_en_i     (rd_en[p]),
         .rd_addr_i   (rd_addr[p*AW +: AW]),
         .regs_i      (regs_q),
         .written_i   (written_q),
         .wr_accept_i (wr_accept_s),
         .wr_addr_i   (wr_addr),
         .wr_data_i   (wr_data),
         .wr_be_i     (wr_be),
         .rd_data_o   (rd_data[p*DATA_W +: DATA_W]),
         .rd_vld_o    (rd_vld[p]),
         .rd_uninit_o (rd_uninit[p])
      );
   end

endmodule

// File: tb/tb_banco_registros_param.sv
// Scoreboard bench: stimulus pushes hand-computed read results, a negedge monitor
// pops and compares whenever a read port presents rd_vld.
module tb_banco_registros_param;

   logic        clk = 1'b0;
   logic        reset;
   logic        wr_valid, wr_ready, clr_req, clr_busy;
   logic [2:0]  wr_addr;
   logic [15:0] wr_data;
   logic [1:0]  wr_be, rd_en, rd_vld, rd_uninit;
   logic [5:0]  rd_addr;
   logic [31:0] rd_data;

   logic        wr_valid_z, wr_ready_z, clr_req_z, clr_busy_z;
   logic [2:0]  wr_addr_z;
   logic [15:0] wr_data_z;
   logic [1:0]  wr_be_z, rd_en_z, rd_vld_z, rd_uninit_z;
   logic [5:0]  rd_addr_z;
   logic [31:0] rd_data_z;

   int n_vec = 0;
   int n_err = 0;
   logic [16:0] q0[$];
   logic [16:0] q1[$];
   logic [16:0] qz[$];

   localparam logic [15:0] FILL [8] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444,
                                         16'h5555, 16'h6666, 16'h7777, 16'h8888};

   always #5 clk = ~clk;

   banco_registros_param #(.DATA_W(16), .NUM_REGS(8), .N_RD(2), .ZERO_REG0(0)) dut (
      .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be), .rd_en(rd_en),
      .rd_addr(rd_addr), .rd_data(rd_data), .rd_vld(rd_vld), .rd_uninit(rd_uninit),
      .clr_req(clr_req), .clr_busy(clr_busy)
   );

   banco_registros_param #(.DATA_W(16), .NUM_REGS(8), .N_RD(2), .ZERO_REG0(1)) dut_z (
      .clk(clk), .reset(reset), .wr_valid(wr_valid_z), .wr_ready(wr_ready_z),
      .wr_addr(wr_addr_z), .wr_data(wr_data_z), .wr_be(wr_be_z), .rd_en(rd_en_z),
      .rd_addr(rd_addr_z), .rd_data(rd_data_z), .rd_vld(rd_vld_z), .rd_uninit(rd_uninit_z),
      .clr_req(clr_req_z), .clr_busy(clr_busy_z)
   );

   // Monitor: pops one expectation per valid read beat.
   always @(negedge clk) begin : mon
      logic [16:0] e;
      if (rd_vld[0]) begin
         n_vec++;
         if (q0.size() == 0) begin
            n_err++; $display("FAIL rd0_unexpected got=%h", {rd_uninit[0], rd_data[15:0]});
         end else begin
            e = q0.pop_front();
            if ({rd_uninit[0], rd_data[15:0]} !== e) begin
               n_err++; $display("FAIL rd0 got={uninit,data}=%h exp=%h", {rd_uninit[0], rd_data[15:0]}, e);
            end
         end
      end
      if (rd_vld[1]) begin
         n_vec++;
         if (q1.size() == 0) begin
            n_err++; $display("FAIL rd1_unexpected got=%h", {rd_uninit[1], rd_data[31:16]});
         end else begin
            e = q1.pop_front();
            if ({rd_uninit[1], rd_data[31:16]} !== e) begin
               n_err++; $display("FAIL rd1 got={uninit,data}=%h exp=%h", {rd_uninit[1], rd_data[31:16]}, e);
            end
         end
      end
      if (rd_vld_z[0]) begin
         n_vec++;
         if (qz.size() == 0) begin
            n_err++; $display("FAIL rdz_unexpected got=%h", {rd_uninit_z[0], rd_data_z[15:0]});
         end else begin
            e = qz.pop_front();
            if ({rd_uninit_z[0], rd_data_z[15:0]} !== e) begin
               n_err++; $display("FAIL rdz got={uninit,data}=%h exp=%h", {rd_uninit_z[0], rd_data_z[15:0]}, e);
            end
         end
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++; $display("FAIL %s got=%h exp=%h", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk); #1;
      wr_valid = 1'b0; rd_en = 2'b00; clr_req = 1'b0;
      wr_valid_z = 1'b0; rd_en_z = 2'b00; clr_req_z = 1'b0;
   endtask

   task automatic wr(input logic [2:0] a, input logic [15:0] d, input logic [1:0] be);
      wr_valid = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
   endtask

   task automatic rd(input int p, input logic [2:0] a, input logic [15:0] d, input logic u);
      rd_en[p] = 1'b1; rd_addr[p*3 +: 3] = a;
      if (p == 0) q0.push_back({u, d}); else q1.push_back({u, d});
   endtask

   task automatic wr_z(input logic [2:0] a, input logic [15:0] d, input logic [1:0] be);
      wr_valid_z = 1'b1; wr_addr_z = a; wr_data_z = d; wr_be_z = be;
   endtask

   task automatic rd_z(input logic [2:0] a, input logic [15:0] d, input logic u);
      rd_en_z[0] = 1'b1; rd_addr_z[2:0] = a;
      qz.push_back({u, d});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      wr_addr = 3'd0; wr_data = 16'h0000; wr_be = 2'b00; rd_addr = 6'd0;
      wr_addr_z = 3'd0; wr_data_z = 16'h0000; wr_be_z = 2'b00; rd_addr_z = 6'd0;
      cyc(); cyc();
      reset = 1'b0;
      check("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
      check("rst_clr_busy", {31'd0, clr_busy}, 32'd0);
      check("rst_rd_vld", {30'd0, rd_vld}, 32'd0);
      check("rst_rd_data", rd_data, 32'h0000_0000);

      // Untouched register after reset.
      rd(0, 3'd6, 16'h0000, 1'b1); cyc();
      // Full write then read; then idle cycle must drop vld and hold data.
      wr(3'd3, 16'hA5C3, 2'b11); cyc();
      rd(0, 3'd3, 16'hA5C3, 1'b0); cyc();
      cyc();
      check("idle_rd_vld", {30'd0, rd_vld}, 32'd0);
      check("hold_rd_data", {16'd0, rd_data[15:0]}, 32'h0000_A5C3);
      // Byte-enable merges.
      wr(3'd3, 16'h1234, 2'b10); cyc();
      rd(0, 3'd3, 16'h12C3, 1'b0); cyc();
      wr(3'd3, 16'hFF77, 2'b01); cyc();
      rd(1, 3'd3, 16'h1277, 1'b0); cyc();
      // Write-first bypass on both ports, then partial bypass plus an unwritten read.
      wr(3'd5, 16'hBEEF, 2'b11); rd(0, 3'd5, 16'hBEEF, 1'b0); rd(1, 3'd5, 16'hBEEF, 1'b0); cyc();
      wr(3'd5, 16'h1100, 2'b10); rd(0, 3'd5, 16'h11EF, 1'b0); rd(1, 3'd6, 16'h0000, 1'b1); cyc();
      // Zero byte enables: data unchanged but register now marked written.
      wr(3'd2, 16'hFFFF, 2'b00); cyc();
      rd(0, 3'd2, 16'h0000, 1'b0); cyc();

      // Hard-zero register 0 variant.
      wr_z(3'd0, 16'hFFFF, 2'b11); cyc();
      rd_z(3'd0, 16'h0000, 1'b0); cyc();
      wr_z(3'd0, 16'hFFFF, 2'b11); rd_z(3'd0, 16'h0000, 1'b0); cyc();
      wr_z(3'd1, 16'h5AA5, 2'b01); cyc();
      rd_z(3'd1, 16'h00A5, 1'b0); cyc();
      rd_z(3'd2, 16'h0000, 1'b1); cyc();

      // Fill the bank; the last write coincides with the clear request.
      for (int i = 0; i < 7; i++) begin
         wr(3'(i), FILL[i], 2'b11); cyc();
      end
      wr(3'd7, FILL[7], 2'b11); clr_req = 1'b1; cyc();
      for (int k = 1; k <= 8; k++) begin
         check($sformatf("clr_busy_c%0d", k), {31'd0, clr_busy}, 32'd1);
         check($sformatf("wr_ready_c%0d", k), {31'd0, wr_ready}, 32'd0);
         if (k == 2) begin
            rd(0, 3'd7, 16'h8888, 1'b0);
            rd(1, 3'd0, 16'h0000, 1'b1);
         end
         if (k == 3) clr_req = 1'b1;
         if (k == 4) wr(3'd0, 16'hFFFF, 2'b11);
         cyc();
      end
      check("clr_done_busy", {31'd0, clr_busy}, 32'd0);
      check("clr_done_ready", {31'd0, wr_ready}, 32'd1);
      for (int i = 0; i < 8; i += 2) begin
         rd(0, 3'(i), 16'h0000, 1'b1); rd(1, 3'(i + 1), 16'h0000, 1'b1); cyc();
      end

      // Reset in the middle of a clear.
      wr(3'd6, 16'h6A6A, 2'b11); cyc();
      wr(3'd1, 16'h1B1B, 2'b11); clr_req = 1'b1; cyc();
      cyc();
      rd(0, 3'd6, 16'h6A6A, 1'b0); cyc();
      cyc();
      reset = 1'b1; rd_en[1] = 1'b1; rd_addr[5:3] = 3'd6; cyc();
      reset = 1'b0;
      check("midclr_rst_busy", {31'd0, clr_busy}, 32'd0);
      check("midclr_rst_ready", {31'd0, wr_ready}, 32'd1);
      check("midclr_rst_vld", {30'd0, rd_vld}, 32'd0);
      check("midclr_rst_data", rd_data, 32'h0000_0000);
      for (int i = 0; i < 8; i += 2) begin
         rd(0, 3'(i), 16'h0000, 1'b1); rd(1, 3'(i + 1), 16'h0000, 1'b1); cyc();
      end

      cyc(); cyc(); cyc();
      check("q0_drained", q0.size(), 32'd0);
      check("q1_drained", q1.size(), 32'd0);
      check("qz_drained", qz.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
